execute_stage: RTL and testbench

- Y86-64 pipeline E stage.
- Owns the D→E pipeline register, drives operands and function to the external 64-bit ALU (2-bit control: 00 add, 01 sub (a−b), 10 xor, 11 and; returns result + signed-overflow flag), and holds the condition-code register (ZF/SF/OF).
- Evaluates branch/cmov conditions and loads the E→M pipeline register consumed by the memory stage.

---
 rtl/execute_stage_if.sv | 60 ++++++
 rtl/execute_stage.sv | 209 ++++++++++++++++++++
 tb/tb_execute_stage.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// Execute-stage bus bundle: decode-stage inputs, external ALU hookup, condition codes and E->M outputs.
// perf_ops/perf_bubbles exist only when EXEC_PERF_CNT_EN is defined.
interface execute_stage_if;
    // No valid/ready flow control: both pipeline registers load every edge,
    // and E_bubble/M_bubble replace the incoming word with a NOP bubble.
    logic        E_bubble;
    logic        M_bubble;
    logic [1:0]  d_stat;
    logic [3:0]  d_icode;
    logic [3:0]  d_ifun;
    logic [63:0] d_valC;
    logic [63:0] d_valA;
    logic [63:0] d_valB;
    logic [3:0]  d_dstE;
    logic [3:0]  d_dstM;
    logic [1:0]  m_stat;
    logic [1:0]  W_stat;
    logic [1:0]  alu_ctrl;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [63:0] alu_result;
    logic        alu_ovf;
    logic        e_Cnd;
    logic [63:0] e_valE;
    logic [3:0]  e_dstE;
    logic        cc_zf;
    logic        cc_sf;
    logic        cc_of;
    logic [1:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
`ifdef EXEC_PERF_CNT_EN
    logic [31:0] perf_ops;
    logic [31:0] perf_bubbles;
`endif

    modport master (
        output E_bubble, M_bubble, d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
               d_dstE, d_dstM, m_stat, W_stat, alu_result, alu_ovf,
        input  alu_ctrl, alu_a, alu_b, e_Cnd, e_valE, e_dstE, cc_zf, cc_sf, cc_of,
`ifdef EXEC_PERF_CNT_EN
               perf_ops, perf_bubbles,
`endif
               M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
    );

    modport slave (
        input  E_bubble, M_bubble, d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
               d_dstE, d_dstM, m_stat, W_stat, alu_result, alu_ovf,
        output alu_ctrl, alu_a, alu_b, e_Cnd, e_valE, e_dstE, cc_zf, cc_sf, cc_of,
`ifdef EXEC_PERF_CNT_EN
               perf_ops, perf_bubbles,
`endif
               M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
    );
endinterface

// File: rtl/execute_stage.sv
// Y86-64 execute stage: D->E register, ALU operand steering, CC register, condition evaluation, E->M register.
// Optional EXEC_PERF_CNT_EN adds OPq and M-bubble event counters.
module execute_stage (
    input  logic           clk,
    input  logic           rst,
    execute_stage_if.slave bus
);
    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOV   = 4'h2;
    localparam logic [3:0] I_IRMOV  = 4'h3;
    localparam logic [3:0] I_RMMOV  = 4'h4;
    localparam logic [3:0] I_MRMOV  = 4'h5;
    localparam logic [3:0] I_OP     = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSH   = 4'hA;
    localparam logic [3:0] I_POP    = 4'hB;

    logic [1:0]  e_stat_q, e_stat_d;
    logic [3:0]  e_icode_q, e_icode_d, e_ifun_q, e_ifun_d;
    logic [63:0] e_valc_q, e_valc_d, e_vala_q, e_vala_d, e_valb_q, e_valb_d;
    logic [3:0]  e_dste_q, e_dste_d, e_dstm_q, e_dstm_d;

    logic [1:0]  m_stat_q, m_stat_d;
    logic [3:0]  m_icode_q, m_icode_d;
    logic        m_cnd_q, m_cnd_d;
    logic [63:0] m_vale_q, m_vale_d, m_vala_q, m_vala_d;
    logic [3:0]  m_dste_q, m_dste_d, m_dstm_q, m_dstm_d;

    logic        cc_zf_q, cc_zf_d, cc_sf_q, cc_sf_d, cc_of_q, cc_of_d;
    logic [63:0] alu_a_op, alu_b_op;
    logic        cond, lt, e_cnd, set_cc;
    logic [3:0]  e_dste_sel;

    always_comb begin
        e_stat_d  = bus.d_stat;
        e_icode_d = bus.d_icode;
        e_ifun_d  = bus.d_ifun;
        e_valc_d  = bus.d_valC;
        e_vala_d  = bus.d_valA;
        e_valb_d  = bus.d_valB;
        e_dste_d  = bus.d_dstE;
        e_dstm_d  = bus.d_dstM;
        if (bus.E_bubble) begin
            e_stat_d  = STAT_AOK;
            e_icode_d = I_NOP;
            e_ifun_d  = 4'h0;
            e_valc_d  = '0;
            e_vala_d  = '0;
            e_valb_d  = '0;
            e_dste_d  = RNONE;
            e_dstm_d  = RNONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_stat_q  <= STAT_AOK;
            e_icode_q <= I_NOP;
            e_ifun_q  <= 4'h0;
            e_valc_q  <= '0;
            e_vala_q  <= '0;
            e_valb_q  <= '0;
            e_dste_q  <= RNONE;
            e_dstm_q  <= RNONE;
        end else begin
            e_stat_q  <= e_stat_d;
            e_icode_q <= e_icode_d;
            e_ifun_q  <= e_ifun_d;
            e_valc_q  <= e_valc_d;
            e_vala_q  <= e_vala_d;
            e_valb_q  <= e_valb_d;
            e_dste_q  <= e_dste_d;
            e_dstm_q  <= e_dstm_d;
        end
    end

    // aluA/aluB in Y86 naming; the ALU sees them swapped so subq yields valB-valA.
    always_comb begin
        case (e_icode_q)
            I_CMOV, I_OP:              alu_a_op = e_vala_q;
            I_IRMOV, I_RMMOV, I_MRMOV: alu_a_op = e_valc_q;
            I_CALL, I_PUSH:            alu_a_op = 64'hFFFF_FFFF_FFFF_FFF8;
            I_RET, I_POP:              alu_a_op = 64'd8;
            default:                   alu_a_op = '0;
        endcase
        case (e_icode_q)
            I_RMMOV, I_MRMOV, I_OP, I_CALL, I_RET, I_PUSH, I_POP: alu_b_op = e_valb_q;
            default:                                             alu_b_op = '0;
        endcase
    end

    assign bus.alu_a    = alu_b_op;
    assign bus.alu_b    = alu_a_op;
    assign bus.alu_ctrl = (e_icode_q == I_OP) ? e_ifun_q[1:0] : 2'b00;
    assign bus.e_valE   = bus.alu_result;

    always_comb begin
        lt = cc_sf_q ^ cc_of_q;
        case (e_ifun_q)
            4'h0:    cond = 1'b1;
            4'h1:    cond = lt | cc_zf_q;
            4'h2:    cond = lt;
            4'h3:    cond = cc_zf_q;
            4'h4:    cond = !cc_zf_q;
            4'h5:    cond = !lt;
            4'h6:    cond = !lt && !cc_zf_q;
            default: cond = 1'b0;
        endcase
    end

    assign e_cnd      = ((e_icode_q == I_CMOV) || (e_icode_q == I_JXX)) && cond;
    assign e_dste_sel = ((e_icode_q == I_CMOV) && !e_cnd) ? RNONE : e_dste_q;
    assign bus.e_Cnd  = e_cnd;
    assign bus.e_dstE = e_dste_sel;

    // An excepting instruction further down must not see CC changed by a younger OPq.
    assign set_cc = (e_icode_q == I_OP) && (bus.m_stat == STAT_AOK) && (bus.W_stat == STAT_AOK);

    always_comb begin
        cc_zf_d = cc_zf_q;
        cc_sf_d = cc_sf_q;
        cc_of_d = cc_of_q;
        if (set_cc) begin
            cc_zf_d = (bus.alu_result == 64'd0);
            cc_sf_d = bus.alu_result[63];
            cc_of_d = bus.alu_ovf;
        end
    end

    always_comb begin
        m_stat_d  = e_stat_q;
        m_icode_d = e_icode_q;
        m_cnd_d   = e_cnd;
        m_vale_d  = bus.alu_result;
        m_vala_d  = e_vala_q;
        m_dste_d  = e_dste_sel;
        m_dstm_d  = e_dstm_q;
        if (bus.M_bubble) begin
            m_stat_d  = STAT_AOK;
            m_icode_d = I_NOP;
            m_cnd_d   = 1'b0;
            m_vale_d  = '0;
            m_vala_d  = '0;
            m_dste_d  = RNONE;
            m_dstm_d  = RNONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_zf_q   <= 1'b1;
            cc_sf_q   <= 1'b0;
            cc_of_q   <= 1'b0;
            m_stat_q  <= STAT_AOK;
            m_icode_q <= I_NOP;
            m_cnd_q   <= 1'b0;
            m_vale_q  <= '0;
            m_vala_q  <= '0;
            m_dste_q  <= RNONE;
            m_dstm_q  <= RNONE;
        end else begin
            cc_zf_q   <= cc_zf_d;
            cc_sf_q   <= cc_sf_d;
            cc_of_q   <= cc_of_d;
            m_stat_q  <= m_stat_d;
            m_icode_q <= m_icode_d;
            m_cnd_q   <= m_cnd_d;
            m_vale_q  <= m_vale_d;
            m_vala_q  <= m_vala_d;
            m_dste_q  <= m_dste_d;
            m_dstm_q  <= m_dstm_d;
        end
    end

    assign bus.cc_zf   = cc_zf_q;
    assign bus.cc_sf   = cc_sf_q;
    assign bus.cc_of   = cc_of_q;
    assign bus.M_stat  = m_stat_q;
    assign bus.M_icode = m_icode_q;
    assign bus.M_Cnd   = m_cnd_q;
    assign bus.M_valE  = m_vale_q;
    assign bus.M_valA  = m_vala_q;
    assign bus.M_dstE  = m_dste_q;
    assign bus.M_dstM  = m_dstm_q;

`ifdef EXEC_PERF_CNT_EN
    logic [31:0] perf_ops_q, perf_ops_d, perf_bubbles_q, perf_bubbles_d;

    assign perf_ops_d     = perf_ops_q + ((e_icode_q == I_OP) ? 32'd1 : 32'd0);
    assign perf_bubbles_d = perf_bubbles_q + (bus.M_bubble ? 32'd1 : 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops_q     <= '0;
            perf_bubbles_q <= '0;
        end else begin
            perf_ops_q     <= perf_ops_d;
            perf_bubbles_q <= perf_bubbles_d;
        end
    end

    assign bus.perf_ops     = perf_ops_q;
    assign bus.perf_bubbles = perf_bubbles_q;
`endif
endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed cases followed by random instruction streams
// compared against an instruction-level reference model; covers EXEC_PERF_CNT_EN when defined.
module tb_execute_stage;
    typedef struct packed {
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valc;
        logic [63:0] vala;
        logic [63:0] valb;
        logic [3:0]  dste;
        logic [3:0]  dstm;
    } e_t;

    typedef struct packed {
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] vale;
        logic [63:0] vala;
        logic [3:0]  dste;
        logic [3:0]  dstm;
    } m_t;

    localparam logic [3:0] RNONE = 4'hF;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    execute_stage_if bus ();
    execute_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

    // External ALU, written from its contract: result and signed overflow.
    logic [63:0] alu_r;
    logic        alu_v;
    always_comb begin
        alu_r = '0;
        alu_v = 1'b0;
        case (bus.alu_ctrl)
            2'b00: begin
                alu_r = bus.alu_a + bus.alu_b;
                alu_v = (bus.alu_a[63] == bus.alu_b[63]) && (alu_r[63] != bus.alu_a[63]);
            end
            2'b01: begin
                alu_r = bus.alu_a - bus.alu_b;
                alu_v = (bus.alu_a[63] != bus.alu_b[63]) && (alu_r[63] != bus.alu_a[63]);
            end
            2'b10:   alu_r = bus.alu_a ^ bus.alu_b;
            default: alu_r = bus.alu_a & bus.alu_b;
        endcase
    end
    assign bus.alu_result = alu_r;
    assign bus.alu_ovf    = alu_v;

    // Reference model state
    e_t          me;
    m_t          mm;
    logic        mzf, msf, mof;
    logic        model_valid = 1'b0;
    logic [31:0] mperf_ops, mperf_bub;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic e_t e_bub();
        e_t e;
        e = '0;
        e.icode = 4'h1;
        e.dste  = RNONE;
        e.dstm  = RNONE;
        return e;
    endfunction

    function automatic m_t m_bub();
        m_t m;
        m = '0;
        m.icode = 4'h1;
        m.dste  = RNONE;
        m.dstm  = RNONE;
        return m;
    endfunction

    function automatic e_t mk(input logic [3:0] icode, input logic [3:0] ifun, input logic [63:0] valc,
                              input logic [63:0] vala, input logic [63:0] valb, input logic [3:0] dste);
        e_t e;
        e.stat = 2'd0; e.icode = icode; e.ifun = ifun;
        e.valc = valc; e.vala = vala; e.valb = valb;
        e.dste = dste; e.dstm = RNONE;
        return e;
    endfunction

    // What each instruction class computes in E, in ISA terms.
    function automatic logic [63:0] ref_vale(input e_t e);
        case (e.icode)
            4'h2:       return e.vala;
            4'h3:       return e.valc;
            4'h4, 4'h5: return e.valb + e.valc;
            4'h6: case (e.ifun[1:0])
                2'd0:    return e.valb + e.vala;
                2'd1:    return e.valb - e.vala;
                2'd2:    return e.valb ^ e.vala;
                default: return e.valb & e.vala;
            endcase
            4'h8, 4'hA: return e.valb - 64'd8;
            4'h9, 4'hB: return e.valb + 64'd8;
            default:    return 64'd0;
        endcase
    endfunction

    function automatic logic ref_ovf(input e_t e);
        logic signed [64:0] s;
        if (e.ifun[1:0] == 2'd0)      s = $signed({e.valb[63], e.valb}) + $signed({e.vala[63], e.vala});
        else if (e.ifun[1:0] == 2'd1) s = $signed({e.valb[63], e.valb}) - $signed({e.vala[63], e.vala});
        else                          return 1'b0;
        return s[64] != s[63];
    endfunction

    function automatic logic ref_cnd(input e_t e, input logic zf, input logic sf, input logic of);
        logic t;
        case (e.ifun)
            4'd0:    t = 1'b1;
            4'd1:    t = (sf != of) || zf;
            4'd2:    t = (sf != of);
            4'd3:    t = zf;
            4'd4:    t = !zf;
            4'd5:    t = (sf == of);
            4'd6:    t = (sf == of) && !zf;
            default: t = 1'b0;
        endcase
        return (e.icode == 4'h2 || e.icode == 4'h7) ? t : 1'b0;
    endfunction

    task automatic check_outputs();
        logic c;
        if (!model_valid) return;
        c = ref_cnd(me, mzf, msf, mof);
        chk("e_valE", bus.e_valE, ref_vale(me));
        chk("e_Cnd", {63'd0, bus.e_Cnd}, {63'd0, c});
        chk("e_dstE", {60'd0, bus.e_dstE}, {60'd0, (me.icode == 4'h2 && !c) ? RNONE : me.dste});
        chk("alu_ctrl", {62'd0, bus.alu_ctrl}, {62'd0, (me.icode == 4'h6) ? me.ifun[1:0] : 2'b00});
        chk("cc_zf", {63'd0, bus.cc_zf}, {63'd0, mzf});
        chk("cc_sf", {63'd0, bus.cc_sf}, {63'd0, msf});
        chk("cc_of", {63'd0, bus.cc_of}, {63'd0, mof});
        chk("M_stat", {62'd0, bus.M_stat}, {62'd0, mm.stat});
        chk("M_icode", {60'd0, bus.M_icode}, {60'd0, mm.icode});
        chk("M_Cnd", {63'd0, bus.M_Cnd}, {63'd0, mm.cnd});
        chk("M_valE", bus.M_valE, mm.vale);
        chk("M_valA", bus.M_valA, mm.vala);
        chk("M_dstE", {60'd0, bus.M_dstE}, {60'd0, mm.dste});
        chk("M_dstM", {60'd0, bus.M_dstM}, {60'd0, mm.dstm});
`ifdef EXEC_PERF_CNT_EN
        chk("perf_ops", {32'd0, bus.perf_ops}, {32'd0, mperf_ops});
        chk("perf_bubbles", {32'd0, bus.perf_bubbles}, {32'd0, mperf_bub});
`endif
    endtask

    // One clock: check current state at the falling edge, then present the inputs for the next rising edge.
    task automatic cycle(input e_t d, input logic eb, input logic mb,
                         input logic [1:0] ms, input logic [1:0] ws, input logic r);
        m_t          nm;
        logic [63:0] v;
        @(negedge clk);
        check_outputs();
        rst          = r;
        bus.E_bubble = eb;
        bus.M_bubble = mb;
        bus.m_stat   = ms;
        bus.W_stat   = ws;
        bus.d_stat   = d.stat;
        bus.d_icode  = d.icode;
        bus.d_ifun   = d.ifun;
        bus.d_valC   = d.valc;
        bus.d_valA   = d.vala;
        bus.d_valB   = d.valb;
        bus.d_dstE   = d.dste;
        bus.d_dstM   = d.dstm;
        if (r) begin
            me = e_bub();
            mm = m_bub();
            mzf = 1'b1; msf = 1'b0; mof = 1'b0;
            mperf_ops = '0;
            mperf_bub = '0;
            model_valid = 1'b1;
        end else begin
            v = ref_vale(me);
            if (mb) nm = m_bub();
            else begin
                nm.stat  = me.stat;
                nm.icode = me.icode;
                nm.cnd   = ref_cnd(me, mzf, msf, mof);
                nm.vale  = v;
                nm.vala  = me.vala;
                nm.dste  = (me.icode == 4'h2 && !nm.cnd) ? RNONE : me.dste;
                nm.dstm  = me.dstm;
            end
            if (me.icode == 4'h6) mperf_ops = mperf_ops + 32'd1;
            if (mb) mperf_bub = mperf_bub + 32'd1;
            if (me.icode == 4'h6 && ms == 2'd0 && ws == 2'd0) begin
                mzf = (v == 64'd0);
                msf = v[63];
                mof = ref_ovf(me);
            end
            mm = nm;
            me = eb ? e_bub() : d;
        end
    endtask

    task automatic run(input e_t d);
        cycle(d, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return 64'hFFFF_FFFF_FFFF_FFFF;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            4:       return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        e_t nop;
        e_t d;
        nop = mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, RNONE);
        rst = 1'b1;
        bus.E_bubble = 1'b0; bus.M_bubble = 1'b0;
        bus.m_stat = 2'd0; bus.W_stat = 2'd0;
        bus.d_stat = 2'd0; bus.d_icode = 4'h1; bus.d_ifun = 4'h0;
        bus.d_valC = '0; bus.d_valA = '0; bus.d_valB = '0;
        bus.d_dstE = RNONE; bus.d_dstM = RNONE;

        cycle(nop, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
        cycle(nop, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
        chk("rst_M_icode", {60'd0, bus.M_icode}, 64'h1);
        chk("rst_M_dstE", {60'd0, bus.M_dstE}, 64'hF);
        chk("rst_M_dstM", {60'd0, bus.M_dstM}, 64'hF);
        chk("rst_zf", {63'd0, bus.cc_zf}, 64'd1);
        chk("rst_sf", {63'd0, bus.cc_sf}, 64'd0);
        chk("rst_of", {63'd0, bus.cc_of}, 64'd0);

        run(mk(4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h2));
        run(nop);
        chk("add_valE", bus.e_valE, 64'h8000_0000_0000_0000);
        run(nop);
        chk("add_zf", {63'd0, bus.cc_zf}, 64'd0);
        chk("add_sf", {63'd0, bus.cc_sf}, 64'd1);
        chk("add_of", {63'd0, bus.cc_of}, 64'd1);

        run(mk(4'h6, 4'h1, 64'd0, 64'd7, 64'd5, 4'h2));
        run(nop);
        chk("sub_ctrl", {62'd0, bus.alu_ctrl}, 64'd1);
        chk("sub_alu_a", bus.alu_a, 64'd5);
        chk("sub_alu_b", bus.alu_b, 64'd7);
        chk("sub_valE", bus.e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
        run(nop);
        chk("sub_sf", {63'd0, bus.cc_sf}, 64'd1);

        run(mk(4'h6, 4'h0, 64'd0, 64'd1, 64'd1, 4'h2));
        run(mk(4'h2, 4'h1, 64'd0, 64'd9, 64'd0, 4'h3));
        run(nop);
        chk("cmovle_cnd", {63'd0, bus.e_Cnd}, 64'd0);
        chk("cmovle_dstE", {60'd0, bus.e_dstE}, 64'hF);
        run(nop);
        chk("cmovle_M_dstE", {60'd0, bus.M_dstE}, 64'hF);

        run(mk(4'hA, 4'h0, 64'd0, 64'd0, 64'h100, 4'h4));
        run(nop);
        chk("push_alu_a", bus.alu_a, 64'h100);
        chk("push_alu_b", bus.alu_b, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("push_valE", bus.e_valE, 64'hF8);

        run(mk(4'h6, 4'h2, 64'd0, 64'd5, 64'd5, 4'h1));
        cycle(nop, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0);
        run(nop);
        chk("supp_zf_hold", {63'd0, bus.cc_zf}, 64'd0);
        run(mk(4'h6, 4'h2, 64'd0, 64'd5, 64'd5, 4'h1));
        run(nop);
        run(nop);
        chk("supp_zf_set", {63'd0, bus.cc_zf}, 64'd1);

        for (int i = 0; i < 500; i++) begin
            d.stat  = 2'($urandom_range(0, 3));
            d.icode = ($urandom_range(0, 1) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
            d.ifun  = (d.icode == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            d.valc  = rnd64();
            d.vala  = rnd64();
            d.valb  = rnd64();
            d.dste  = 4'($urandom_range(0, 15));
            d.dstm  = 4'($urandom_range(0, 15));
            cycle(d,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0,
                  ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                  ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                  $urandom_range(0, 99) == 0);
        end
        run(nop);
        run(nop);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
